usart_tx: RTL and testbench

USART_TX -- requirements
Module: usart_tx

---
 rtl/usart_pkg.sv | 34 +++
 rtl/usart_baud_gen.sv | 36 +++
 rtl/usart_tx.sv | 116 +++++++++++
 tb/tb_usart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// usart_pkg: shared FSM states, frame-format encodings and oversample constants for the USART transmitter
package usart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  localparam logic [1:0] UPM_NONE = 2'b00;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  localparam int OS_NORM = 16;
  localparam int OS_2X   = 8;

  // reserved size codes fall back to 8 data bits
  function automatic logic [3:0] data_bits(input logic [2:0] ucsz);
    return ucsz == UCSZ_5 ? 4'd5 :
           ucsz == UCSZ_6 ? 4'd6 :
           ucsz == UCSZ_7 ? 4'd7 :
           ucsz == UCSZ_9 ? 4'd9 : 4'd8;
  endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// usart_baud_gen: prescaler plus oversample counter producing one bit tick per (ubrr+1)*16 or *8 clocks
module usart_baud_gen
  import usart_pkg::*;
(
  input  logic        i_fosk,
  input  logic        i_rst_n,
  input  logic [11:0] i_ubrr,
  input  logic        i_u2x,
  input  logic        i_we_ubrrl,
  output logic        o_tick
);

  logic [11:0] presc;
  logic [3:0]  osc;
  logic [3:0]  os_max;

  assign os_max = i_u2x ? 4'(OS_2X - 1) : 4'(OS_NORM - 1);
  // >= keeps the counter wrapping cleanly if u2x is switched mid-count
  assign o_tick = !i_we_ubrrl && presc == '0 && osc >= os_max;

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
      osc   <= '0;
    end else if (i_we_ubrrl) begin
      presc <= i_ubrr;
      osc   <= '0;
    end else if (presc == '0) begin
      presc <= i_ubrr;
      osc   <= osc >= os_max ? '0 : osc + 4'd1;
    end else begin
      presc <= presc - 12'd1;
    end
  end

endmodule

// File: rtl/usart_tx.sv
// usart_tx: USART transmitter (5-9 data bits, 1-2 stops); parity bit only when USART_TX_PARITY_EN is defined
module usart_tx
  import usart_pkg::*;
(
  input  logic        i_fosk,
  input  logic        i_rst_n,
  input  logic [11:0] i_ubrr,
  input  logic        i_u2x,
  input  logic        i_we_ubrrl,
  input  logic        i_txen,
  input  logic [2:0]  i_ucsz,
  input  logic        i_usbs,
  input  logic [1:0]  i_upm,
  input  logic        i_we_udr_tr,
  input  logic [7:0]  i_udr_tr,
  input  logic        i_tx8,
  output logic        o_txd,
  output logic        o_udre,
  output logic        o_txc
);

  tx_state_t  state;
  logic       pending, tick, last_stop, go, shift, data_last, usbs_r;
  logic       to_parity, par_bit;
  logic [8:0] sh;
  logic [3:0] nbits, cnt;

  usart_baud_gen u_baud (
    .i_fosk     (i_fosk),
    .i_rst_n    (i_rst_n),
    .i_ubrr     (i_ubrr),
    .i_u2x      (i_u2x),
    .i_we_ubrrl (i_we_ubrrl),
    .o_tick     (tick)
  );

  assign o_udre    = ~pending;
  assign last_stop = (state == ST_STOP1 && !usbs_r) || state == ST_STOP2;
  assign go        = tick && pending && i_txen && (state == ST_IDLE || last_stop);
  assign data_last = state == ST_DATA && cnt == nbits - 4'd1;
  assign shift     = tick && !go && (state == ST_START || (state == ST_DATA && !data_last));

`ifdef USART_TX_PARITY_EN
  logic par_en, par;
  assign to_parity = par_en;
  assign par_bit   = par;
  // parity accumulates over exactly the bits put on the line
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_en <= 1'b0;
      par    <= 1'b0;
    end else if (go) begin
      par_en <= i_upm[1];
      par    <= i_upm == UPM_ODD;
    end else if (shift) begin
      par    <= par ^ sh[0];
    end
  end
`else
  logic unused_upm;
  assign unused_upm = ^i_upm;
  assign to_parity  = 1'b0;
  assign par_bit    = 1'b1;
`endif

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_txd   <= 1'b1;
      o_txc   <= 1'b0;
      pending <= 1'b0;
      sh      <= '0;
      nbits   <= 4'd8;
      cnt     <= '0;
      usbs_r  <= 1'b0;
    end else begin
      if (go) begin
        state   <= ST_START;
        o_txd   <= 1'b0;
        sh      <= {i_tx8, i_udr_tr};
        nbits   <= data_bits(i_ucsz);
        cnt     <= '0;
        usbs_r  <= i_usbs;
        pending <= 1'b0;
      end else if (shift) begin
        state   <= ST_DATA;
        o_txd   <= sh[0];
        sh      <= sh >> 1;
        cnt     <= state == ST_START ? 4'd0 : cnt + 4'd1;
      end else if (tick) begin
        case (state)
          ST_DATA: begin
            state <= to_parity ? ST_PARITY : ST_STOP1;
            o_txd <= to_parity ? par_bit : 1'b1;
          end
          ST_PARITY: begin
            state <= ST_STOP1;
            o_txd <= 1'b1;
          end
          ST_STOP1, ST_STOP2: begin
            state <= usbs_r && state == ST_STOP1 ? ST_STOP2 : ST_IDLE;
            o_txd <= 1'b1;
            o_txc <= usbs_r && state == ST_STOP1 ? o_txc : ~pending;
          end
          default: ;
        endcase
      end
      // a new write wins over the load/complete updates above
      if (i_we_udr_tr) begin
        pending <= 1'b1;
        o_txc   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usart_tx.sv
// tb_usart_tx: randomized scoreboard bench for usart_tx with a bit-list frame model
module tb_usart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ubrr = '0;
  logic        u2x = 1'b1, we_ubrrl = 1'b0, txen = 1'b1;
  logic [2:0]  ucsz = 3'b011;
  logic        usbs = 1'b0;
  logic [1:0]  upm = 2'b00;
  logic        we_udr = 1'b0;
  logic [7:0]  udr = '0;
  logic        tx8 = 1'b0;
  logic        txd, udre, txc;

  int          total = 0, bad = 0;
  int          bitc = 8;
  bit          mon_en = 1'b1;
  logic [63:0] cyc = '0;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;
  frame_t exp_q[$];

`ifdef USART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  usart_tx dut (
    .i_fosk(clk), .i_rst_n(rst_n), .i_ubrr(ubrr), .i_u2x(u2x), .i_we_ubrrl(we_ubrrl),
    .i_txen(txen), .i_ucsz(ucsz), .i_usbs(usbs), .i_upm(upm), .i_we_udr_tr(we_udr),
    .i_udr_tr(udr), .i_tx8(tx8), .o_txd(txd), .o_udre(udre), .o_txc(txc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame as line bits in send order: start, data LSB first, optional parity, stops
  function automatic frame_t model(input logic [7:0] d, input logic t8, input logic [2:0] cz,
                                   input logic [1:0] pm, input logic sb);
    frame_t     e;
    logic [8:0] v;
    int         n, k, ones;
    v = {t8, d};
    n = cz == 3'd0 ? 5 : cz == 3'd1 ? 6 : cz == 3'd2 ? 7 : cz == 3'd7 ? 9 : 8;
    e.bits = '0;
    k = 1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      e.bits[k] = v[i];
      ones += int'(v[i]);
      k++;
    end
    if (PAR && pm[1]) begin
      e.bits[k] = logic'(ones % 2) ^ pm[0];
      k++;
    end
    e.bits[k] = 1'b1;
    k++;
    if (sb) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.len = k;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic t8, input logic [2:0] cz,
                      input logic [1:0] pm, input logic sb, input bit push, output int len);
    frame_t e;
    @(posedge clk);
    #1;
    udr = d; tx8 = t8; ucsz = cz; upm = pm; usbs = sb; we_udr = 1'b1;
    e = model(d, t8, cz, pm, sb);
    len = e.len;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 we_udr = 1'b0;
    @(negedge clk);
    check("udre_fall", udre, 1'b0);
    check("txc_clear", txc, 1'b0);
  endtask

  task automatic wait_load(output logic [63:0] t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (udre !== 1'b1 && n < 3000);
    check("load_seen", udre, 1'b1);
    check("start_at_load", txd, 1'b0);
    t = cyc;
  endtask

  task automatic wait_done(input logic [63:0] t0, input int exp);
    int n = 0;
    while (txc !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("frame_cycles", cyc - t0, 64'(exp));
  endtask

  task automatic set_baud(input logic [11:0] ub, input logic dbl, input int bc);
    @(posedge clk);
    #1 ubrr = ub; u2x = dbl; we_ubrrl = 1'b1;
    @(posedge clk);
    #1 we_ubrrl = 1'b0;
    bitc = bc;
  endtask

  initial begin : monitor
    frame_t      e;
    logic [15:0] got;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame start bit seen with empty scoreboard");
          repeat (bitc * 14) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          got = '0;
          repeat (bitc / 2) @(negedge clk);
          for (int i = 0; i < e.len; i++) begin
            got[i] = txd;
            if (i < e.len - 1) repeat (bitc) @(negedge clk);
          end
          total++;
          if (got !== e.bits) begin
            bad++;
            $display("FAIL frame got=%b exp=%b len=%0d", got, e.bits, e.len);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] t0, t1;
    int          la, lb;
    logic [7:0]  d;
    logic [2:0]  cz;
    logic [1:0]  pm;
    logic        sb, t8;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_udre", udre, 1'b1);
    check("rst_txc", txc, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_txd", txd, 1'b1);
    check("idle_txc", txc, 1'b0);

    // directed: 8N1, 8E1, 8O1, 9N2, 5N1
    send(8'h55, 1'b0, 3'b011, 2'b00, 1'b0, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);
    check("len_8n1", la, 10);
    send(8'h07, 1'b0, 3'b011, 2'b10, 1'b0, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);
    send(8'h07, 1'b0, 3'b011, 2'b11, 1'b0, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);
    send(8'h00, 1'b1, 3'b111, 2'b00, 1'b1, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);
    send(8'hFF, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);

    // back-to-back: second write lands during the first frame's data bits
    send(8'hA3, 1'b0, 3'b011, 2'b00, 1'b0, 1'b1, la); wait_load(t0);
    repeat (30) @(negedge clk);
    send(8'h3C, 1'b0, 3'b011, 2'b00, 1'b0, 1'b1, lb); wait_load(t1);
    check("b2b_no_gap", t1 - t0, 64'(la * bitc));
    wait_done(t0, (la + lb) * bitc);

    // txen low holds the pending byte; the second write overwrites the first
    txen = 1'b0;
    send(8'h11, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, la);
    send(8'h96, 1'b0, 3'b011, 2'b00, 1'b0, 1'b1, la);
    repeat (40) @(negedge clk);
    check("txen_hold_txd", txd, 1'b1);
    check("txen_hold_udre", udre, 1'b0);
    txen = 1'b1;
    wait_load(t0); wait_done(t0, la * bitc);

    // dropping txen mid-frame lets the frame finish
    send(8'h5A, 1'b1, 3'b111, 2'b00, 1'b1, 1'b1, la); wait_load(t0);
    txen = 1'b0;
    wait_done(t0, la * bitc);
    txen = 1'b1;

    // reset during the 4th data bit, then a clean frame
    mon_en = 1'b0;
    send(8'h55, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, la); wait_load(t0);
    repeat (35) @(negedge clk);
    check("pre_reset_bit3", txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_udre", udre, 1'b1);
    check("rst_mid_txc", txc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    send(8'hC3, 1'b0, 3'b011, 2'b00, 1'b0, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);

    // slower baud: ubrr=2, 16x oversample -> 48 clocks per bit
    set_baud(12'd2, 1'b0, 48);
    send(8'h6B, 1'b0, 3'b010, 2'b10, 1'b1, 1'b1, la); wait_load(t0); wait_done(t0, la * bitc);
    set_baud(12'd0, 1'b1, 8);

    // randomized frames, singles and back-to-back pairs
    for (int k = 0; k < 14; k++) begin
      d = 8'($urandom); t8 = 1'($urandom); cz = 3'($urandom_range(0, 7));
      pm = 2'($urandom); sb = 1'($urandom);
      send(d, t8, cz, pm, sb, 1'b1, la); wait_load(t0);
      if (k % 3 == 2) begin
        repeat ($urandom_range(10, 40)) @(negedge clk);
        send(8'($urandom), t8, cz, pm, sb, 1'b1, lb); wait_load(t1);
        check("rand_b2b_gap", t1 - t0, 64'(la * bitc));
        la += lb;
      end
      wait_done(t0, la * bitc);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
